// File: rtl/mac_stage_pipe.sv
// Signed multiply-add pipeline stage y = x*a + c for the Horner polynomial evaluator.
// Three enable-gated register stages with optional scaling shift, rounding, saturation and overflow flags.
module mac_stage_pipe #(
    parameter int DW    = 15,
    parameter int AW    = 18,
    parameter int CW    = 21,
    parameter int OW    = 16,
    parameter int SHIFT = 0,
    parameter int ROUND = 0,
    parameter int SAT   = 0,
    parameter int TW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] x_in,
    input  logic signed [AW-1:0] a_in,
    input  logic signed [CW-1:0] c_in,
    input  logic [TW-1:0]        tag_in,
    input  logic                 ovf_clr,
    output logic signed [OW-1:0] y_out,
    output logic                 y_valid,
    output logic [TW-1:0]        y_tag,
    output logic                 y_ovf,
    output logic                 ovf_sticky
);

    localparam int PW  = DW + AW;
    localparam int QW  = PW + 1;
    localparam int GW  = QW + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [GW-1:0] RND_ONE = GW'(1);
    localparam logic signed [GW-1:0] RND     = (ROUND != 0 && SHIFT > 0) ? (RND_ONE <<< RSH) : '0;
    localparam logic signed [GW-1:0] R_MAX   = {{(GW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [GW-1:0] R_MIN   = {{(GW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic signed [OW-1:0] Y_MAX   = R_MAX[OW-1:0];
    localparam logic signed [OW-1:0] Y_MIN   = R_MIN[OW-1:0];

    logic signed [DW-1:0] x_s1_reg;
    logic signed [AW-1:0] a_s1_reg;
    logic signed [CW-1:0] c_s1_reg;
    logic [TW-1:0]        tag_s1_reg;
    logic                 vld_s1_reg;

    logic signed [PW-1:0] p_s2_reg;
    logic signed [QW-1:0] c_s2_reg;
    logic [TW-1:0]        tag_s2_reg;
    logic                 vld_s2_reg;

    logic signed [OW-1:0] y_reg;
    logic [TW-1:0]        tag_s3_reg;
    logic                 vld_s3_reg;
    logic                 ovf_s3_reg;
    logic                 sticky_reg;

    logic signed [PW-1:0] p_next;
    logic signed [QW-1:0] c_next;
    logic signed [QW-1:0] q_sum;
    logic signed [GW-1:0] g_sum;
    logic signed [GW-1:0] r_val;
    logic                 ovf_next;
    logic signed [OW-1:0] y_next;

    // The extra guard bit in g_sum absorbs any carry from the rounding constant.
    always_comb begin
        p_next   = PW'(x_s1_reg) * PW'(a_s1_reg);
        c_next   = QW'(c_s1_reg);
        q_sum    = QW'(p_s2_reg) + c_s2_reg;
        g_sum    = GW'(q_sum) + RND;
        r_val    = g_sum >>> SHIFT;
        ovf_next = (r_val > R_MAX) || (r_val < R_MIN);
        y_next   = r_val[OW-1:0];
        if (SAT != 0 && ovf_next) begin
            y_next = r_val[GW-1] ? Y_MIN : Y_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_s1_reg   <= '0;
            a_s1_reg   <= '0;
            c_s1_reg   <= '0;
            tag_s1_reg <= '0;
            vld_s1_reg <= 1'b0;
            p_s2_reg   <= '0;
            c_s2_reg   <= '0;
            tag_s2_reg <= '0;
            vld_s2_reg <= 1'b0;
            y_reg      <= '0;
            tag_s3_reg <= '0;
            vld_s3_reg <= 1'b0;
            ovf_s3_reg <= 1'b0;
        end else if (en) begin
            x_s1_reg   <= x_in;
            a_s1_reg   <= a_in;
            c_s1_reg   <= c_in;
            tag_s1_reg <= tag_in;
            vld_s1_reg <= in_valid;
            p_s2_reg   <= p_next;
            c_s2_reg   <= c_next;
            tag_s2_reg <= tag_s1_reg;
            vld_s2_reg <= vld_s1_reg;
            y_reg      <= y_next;
            tag_s3_reg <= tag_s2_reg;
            vld_s3_reg <= vld_s2_reg;
            ovf_s3_reg <= ovf_next && vld_s2_reg;
        end
    end

    // Setting takes priority over a simultaneous clear; clearing ignores en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_reg <= 1'b0;
        end else if (en && vld_s2_reg && ovf_next) begin
            sticky_reg <= 1'b1;
        end else if (ovf_clr) begin
            sticky_reg <= 1'b0;
        end
    end

    assign y_out      = y_reg;
    assign y_valid    = vld_s3_reg;
    assign y_tag      = tag_s3_reg;
    assign y_ovf      = ovf_s3_reg;
    assign ovf_sticky = sticky_reg;

endmodule
